// File: rtl/sram_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sram_stage_sequencer
// Purpose  : Runs the selected processing stages in ascending index order and
//            hands each one exclusive SRAM ownership until it writes its end
//            address. A default reader owns the bus whenever no stage runs.
//            Supports per-run stage masking, write-inactivity timeout, abort
//            and a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module sram_stage_sequencer #(
  parameter int N_CLIENTS      = 3,
  parameter int ADDR_W         = 18,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_W      = 26,
  parameter int TIMEOUT_CYCLES = 49999999
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          Start,
  input  logic                          Abort,
  input  logic [N_CLIENTS-1:0]          Stage_mask,
  input  logic [N_CLIENTS*ADDR_W-1:0]   Stage_end_address,
  input  logic [N_CLIENTS*ADDR_W-1:0]   Client_address,
  input  logic [N_CLIENTS*DATA_W-1:0]   Client_write_data,
  input  logic [N_CLIENTS-1:0]          Client_we_n,
  input  logic [ADDR_W-1:0]             Default_address,
  output logic [N_CLIENTS-1:0]          Client_enable,
  output logic                          Default_enable,
  output logic [ADDR_W-1:0]             SRAM_address,
  output logic [DATA_W-1:0]             SRAM_write_data,
  output logic                          SRAM_we_n,
  output logic [3:0]                    Active_stage,
  output logic                          Busy,
  output logic                          Done,
  output logic                          Timeout_error
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENABLE = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Timer value at which a silent stage is declared stuck.
  localparam logic [TIMEOUT_W-1:0] c_timeout_last = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [N_CLIENTS-1:0]   mask_q, mask_d;
  logic [3:0]             active_q, active_d;
  logic [N_CLIENTS-1:0]   client_en_q, client_en_d;
  logic                   default_en_q, default_en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   timeout_q, timeout_d;
  logic [TIMEOUT_W-1:0]   timer_q, timer_d;

  logic [ADDR_W-1:0]      w_sel_addr;
  logic [ADDR_W-1:0]      w_sel_end;
  logic [DATA_W-1:0]      w_sel_data;
  logic                   w_sel_we_n;
  logic [N_CLIENTS-1:0]   w_active_onehot;
  logic [3:0]             w_first_stage;
  logic [3:0]             w_next_stage;
  logic                   w_next_valid;
  logic                   w_complete;
  logic                   w_owns_bus;

  // Select the owning stage's buses and find the first / next masked stage.
  always_comb begin
    w_sel_addr      = '0;
    w_sel_end       = '0;
    w_sel_data      = '0;
    w_sel_we_n      = 1'b1;
    w_active_onehot = '0;
    w_first_stage   = '0;
    w_next_stage    = '0;
    w_next_valid    = 1'b0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (active_q == 4'(i)) begin
        w_sel_addr         = Client_address[i*ADDR_W +: ADDR_W];
        w_sel_end          = Stage_end_address[i*ADDR_W +: ADDR_W];
        w_sel_data         = Client_write_data[i*DATA_W +: DATA_W];
        w_sel_we_n         = Client_we_n[i];
        w_active_onehot[i] = 1'b1;
      end
    end
    // Descending scan so the lowest qualifying index wins.
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      if (Stage_mask[i]) begin
        w_first_stage = 4'(i);
      end
      if (mask_q[i] && (4'(i) > active_q)) begin
        w_next_stage = 4'(i);
        w_next_valid = 1'b1;
      end
    end
  end

  assign w_complete = !w_sel_we_n && (w_sel_addr == w_sel_end);
  assign w_owns_bus = (state_q == S_ENABLE) || (state_q == S_WAIT);

  // Next-state and registered-output computation for the sequencer FSM.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    active_d     = active_q;
    client_en_d  = client_en_q;
    default_en_d = default_en_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    timeout_d    = timeout_q;
    timer_d      = timer_q;

    if ((state_q != S_IDLE) && Abort) begin
      state_d      = S_IDLE;
      client_en_d  = '0;
      busy_d       = 1'b0;
      default_en_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            mask_d    = Stage_mask;
            timeout_d = 1'b0;
            if (Stage_mask != '0) begin
              state_d      = S_ENABLE;
              active_d     = w_first_stage;
              busy_d       = 1'b1;
              default_en_d = 1'b0;
            end else begin
              state_d      = S_DONE;
              done_d       = 1'b1;
              busy_d       = 1'b0;
              default_en_d = 1'b1;
            end
          end
        end
        S_ENABLE: begin
          client_en_d = client_en_q | w_active_onehot;
          timer_d     = '0;
          state_d     = S_WAIT;
        end
        S_WAIT: begin
          // Any write by the owner counts as activity.
          if (!w_sel_we_n) begin
            timer_d = '0;
          end else begin
            timer_d = timer_q + TIMEOUT_W'(1);
          end
          if (w_complete) begin
            client_en_d = client_en_q & ~w_active_onehot;
            if (w_next_valid) begin
              state_d  = S_ENABLE;
              active_d = w_next_stage;
            end else begin
              state_d      = S_DONE;
              done_d       = 1'b1;
              busy_d       = 1'b0;
              default_en_d = 1'b1;
            end
          end else if (timer_q == c_timeout_last) begin
            client_en_d  = '0;
            timeout_d    = 1'b1;
            busy_d       = 1'b0;
            default_en_d = 1'b1;
            timer_d      = '0;
            state_d      = S_IDLE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      mask_q       <= '0;
      active_q     <= '0;
      client_en_q  <= '0;
      default_en_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      active_q     <= active_d;
      client_en_q  <= client_en_d;
      default_en_q <= default_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      timer_q      <= timer_d;
    end
  end

  // Bus mux: the owning stage drives SRAM, otherwise the default reader.
  always_comb begin
    if (w_owns_bus) begin
      SRAM_address    = w_sel_addr;
      SRAM_write_data = w_sel_data;
      SRAM_we_n       = w_sel_we_n;
    end else begin
      SRAM_address    = Default_address;
      SRAM_write_data = '0;
      SRAM_we_n       = 1'b1;
    end
  end

  assign Client_enable  = client_en_q;
  assign Default_enable = default_en_q;
  assign Active_stage   = active_q;
  assign Busy           = busy_q;
  assign Done           = done_q;
  assign Timeout_error  = timeout_q;

endmodule
`default_nettype wire

// File: doc/sram_stage_sequencer.md
Name: sram_stage_sequencer

Overview:
- Parametrised SRAM bus sequencer and arbiter. It runs N_CLIENTS processing stages (UART load, M2, M1, ...) in ascending index order. Each stage gets an enable and exclusive SRAM ownership until it writes its programmed end address.
- Adds per-run stage masking, a write-inactivity timeout, abort, and a done pulse.
- A default reader (VGA) owns the bus whenever no stage runs.
- Sits at top level between client units and SRAM_Controller.

Parameters:
N_CLIENTS, 3, number of sequenced stages (1..15)
ADDR_W, 18, SRAM address width
DATA_W, 16, SRAM data width
TIMEOUT_W, 26, timeout counter width
TIMEOUT_CYCLES, 49999999, inactivity limit in cycles (>=2)

Ports:
Clock  in  1  system clock; the block uses this single clock
Reset  in  1  synchronous, active-high reset
Start  in  1  begin a run (sampled in IDLE only)
Abort  in  1  cancel the current run
Stage_mask  in  N_CLIENTS  bit i=1 means run stage i; latched at Start
Stage_end_address  in  N_CLIENTS*ADDR_W  per-stage completion address, slice i = [i*ADDR_W +: ADDR_W]
Client_address  in  N_CLIENTS*ADDR_W  per-client SRAM address
Client_write_data  in  N_CLIENTS*DATA_W  per-client write data
Client_we_n  in  N_CLIENTS  per-client write enable, active low
Default_address  in  ADDR_W  default (VGA) read address
Client_enable  out  N_CLIENTS  enable to each client
Default_enable  out  1  default reader enable
SRAM_address  out  ADDR_W  to SRAM_Controller
SRAM_write_data  out  DATA_W  to SRAM_Controller
SRAM_we_n  out  1  to SRAM_Controller
Active_stage  out  4  index of the owning stage
Busy  out  1  run in progress
Done  out  1  one-cycle pulse on successful run end
Timeout_error  out  1  sticky timeout flag

Behaviour:
- Reset values: state IDLE, Client_enable=0, Default_enable=1, Active_stage=0, Busy=0, Done=0, Timeout_error=0, mask latch=0, timer=0.
- States: IDLE, ENABLE, WAIT, DONE.
- IDLE, on Start=1 (cycle t):
  - Latch Stage_mask and clear Timeout_error.
  - If the mask is nonzero: at t+1 the state is ENABLE, Active_stage = lowest set bit, Busy=1, Default_enable=0.
  - If the mask is zero: go to DONE.
- ENABLE:
  - Client_enable[Active_stage] <= 1 and timer <= 0; next state WAIT.
  - The enable is therefore visible at t+2.
- WAIT, evaluated each cycle:
  - Completion = Client_we_n[s]==0 and Client_address[s]==Stage_end_address[s], where s = Active_stage.
  - On completion: Client_enable[s] <= 0. Next state is ENABLE with the next higher set mask bit, or DONE if none remains.
  - Timer clears on any Client_we_n[s]==0 and increments otherwise.
  - If timer==TIMEOUT_CYCLES-1 without completion: Client_enable <= 0, Timeout_error <= 1, Busy <= 0, Default_enable <= 1, go IDLE.
  - Completion has priority over timeout in the same cycle.
- DONE: Done=1 for exactly this one cycle, Busy=0, Default_enable=1; next state IDLE.
- Abort=1 in any non-IDLE state:
  - Next cycle: IDLE, all Client_enable=0, Busy=0, Default_enable=1.
  - No Done pulse; Timeout_error unchanged.
  - Abort takes priority over completion and timeout. Reset takes priority over everything.
- Start while not IDLE is ignored. Stage_mask changes after Start are ignored.
- Bus mux (combinational from registered state and Active_stage):
  - ENABLE or WAIT: SRAM_address/SRAM_write_data/SRAM_we_n = slice Active_stage of the client buses.
  - Otherwise: SRAM_address = Default_address, SRAM_write_data = 0, SRAM_we_n = 1.
- Non-owner Client_we_n values are ignored and can never reach SRAM.
- Timer width TIMEOUT_W; TIMEOUT_CYCLES must be < 2^TIMEOUT_W; the timer never wraps.
- Active_stage holds its last value in IDLE and DONE.

Test Plan:
- N=3, TIMEOUT_CYCLES=16, mask=3'b111, end addresses 10/20/30. Each client writes sequential addresses 0..end, one write per cycle. Required: stages run 0->1->2, each Client_enable high only during its stage, Done pulses once, Busy falls with Done, Default_enable returns to 1.
- Mask=3'b101. Required: stage 1 never enabled; Active_stage goes 0 then 2; Done pulses once.
- Mask=3'b000, Start. Required: Done pulses at t+1, and no Client_enable ever asserts.
- Stage 0 stops writing. Required: 16 cycles after its last write, Timeout_error=1, enable drops, state returns to IDLE, no Done. A following Start clears Timeout_error.
- Abort asserted while stage 1 is in WAIT. Required: next cycle all enables=0, Busy=0, SRAM_we_n=1, SRAM_address=Default_address, no Done.
- Non-owner client drives we_n=0 at its end address while another stage owns the bus. Required: SRAM_we_n follows the owner only; no false completion. Reset mid-run returns every output to its reset value on the next edge.
